// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle ALU: opcodes, FSM states and the zero condition code.
// The multiplier opcode is only legal when the design is built with ALU_MUL_EN.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NOT  = 3'b010,
        OP_PASS = 3'b011,
        OP_SHL  = 3'b100,
        OP_SRA  = 3'b101,
        OP_MUL  = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [2:0] NZP_ZERO = 3'b010;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, product truncated to WIDTH.
// Only instantiated by multicycle_alu when ALU_MUL_EN is defined.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    count;

    // The product is taken from acc_next so the last partial sum lands in the
    // caller's result register on the same edge that finishes the final bit.
    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign done     = (count == CW'(1));
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= CW'(WIDTH);
        end else if (count != '0) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Valid/ready ALU: single-cycle ops go IDLE->DONE, MUL goes through EXEC for WIDTH cycles.
// Define ALU_MUL_EN to build the multiplier; otherwise op 110 reports as illegal.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       nzp,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    state_e                  state;
    logic                    accept;
    logic                    go_exec;
    logic                    illegal;
    logic [WIDTH-1:0]        res;
    logic signed [WIDTH-1:0] a_s;
    logic [SHW-1:0]          shamt;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        if (v == '0)
            return NZP_ZERO;
        return v[WIDTH-1] ? 3'b100 : 3'b001;
    endfunction

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign a_s       = a;
    assign shamt     = b[SHW-1:0];

    always_comb begin
        res     = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  res = a + b;
            OP_AND:  res = a & b;
            OP_NOT:  res = ~a;
            OP_PASS: res = a;
            OP_SHL:  res = a << shamt;
            OP_SRA:  res = a_s >>> shamt;
            default: illegal = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign go_exec = (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && go_exec),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign go_exec = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            out   <= '0;
            nzp   <= NZP_ZERO;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (go_exec) begin
                            state <= ST_EXEC;
                        end else begin
                            state <= ST_DONE;
                            out   <= res;
                            nzp   <= nzp_of(res);
                            err   <= illegal;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                ST_EXEC: begin
                    if (mul_done) begin
                        state <= ST_DONE;
                        out   <= mul_product;
                        nzp   <= nzp_of(mul_product);
                        err   <= 1'b0;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu; follows ALU_MUL_EN to decide what op 110 should do.
module tb_multicycle_alu;

    localparam int WIDTH = 16;
    localparam int SHW   = $clog2(WIDTH);
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out;
    logic [2:0]       nzp;
    logic             err;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic [2:0]       nzp;
        logic             err;
        int               lat;
        int               vcyc;
    } exp_t;

    exp_t sb[$];
    int   check_count = 0;
    int   error_count = 0;
    int   cyc = 0;
    bit   prev_hs = 1'b1;
    bit   rand_ready = 1'b0;

    multicycle_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .nzp       (nzp),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] o, input logic [2:0] n, input logic e, input int lat);
        exp_t r;
        r.out  = o;
        r.nzp  = n;
        r.err  = e;
        r.lat  = lat;
        r.vcyc = 0;
        return r;
    endfunction

    function automatic exp_t model(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t             r;
        logic [WIDTH-1:0] v;
        logic [2*WIDTH-1:0] p;
        logic [SHW-1:0]   sh;
        sh = y[SHW-1:0];
        v = '0;
        r.err = 1'b0;
        r.lat = 0;
        r.vcyc = 0;
        case (o)
            3'd0: v = x + y;
            3'd1: v = x & y;
            3'd2: v = ~x;
            3'd3: v = x;
            3'd4: v = x << sh;
            3'd5: v = $unsigned($signed(x) >>> sh);
            3'd6: begin
                if (MUL_EN) begin
                    p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
                    v = p[WIDTH-1:0];
                    r.lat = WIDTH;
                end else begin
                    r.err = 1'b1;
                end
            end
            default: r.err = 1'b1;
        endcase
        r.out = v;
        r.nzp = (v == '0) ? 3'b010 : (v[WIDTH-1] ? 3'b100 : 3'b001);
        return r;
    endfunction

    // Called at posedge+1; holds the request until accepted, records when the result must appear.
    task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input exp_t e);
        int   n;
        exp_t q;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        q = e;
        q.vcyc = cyc + 1 + e.lat;
        sb.push_back(q);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Result monitor: every visible result is compared against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hs = 1'b1;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 64'd1, 64'd0);
            end else begin
                if (prev_hs)
                    checkOutput("latency", 64'(cyc), 64'(sb[0].vcyc));
                checkOutput("out", 64'(out), 64'(sb[0].out));
                checkOutput("nzp", 64'(nzp), 64'(sb[0].nzp));
                checkOutput("err", 64'(err), 64'(sb[0].err));
                if (out_ready)
                    void'(sb.pop_front());
            end
            prev_hs = out_ready;
        end else begin
            prev_hs = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready)
            out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]       ro;
        logic [WIDTH-1:0] rx;
        logic [WIDTH-1:0] ry;
        int               n;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_out", 64'(out), 64'd0);
        checkOutput("rst_nzp", 64'(nzp), 64'b010);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #4;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        applyStimulus(3'd0, 16'h7FFF, 16'h0001, mk(16'h8000, 3'b100, 1'b0, 0));
        idle(2);

        applyStimulus(3'd2, 16'hFFFF, 16'h0000, mk(16'h0000, 3'b010, 1'b0, 0));
        applyStimulus(3'd3, 16'h0000, 16'h1234, mk(16'h0000, 3'b010, 1'b0, 0));

        applyStimulus(3'd5, 16'h8000, 16'd15, mk(16'hFFFF, 3'b100, 1'b0, 0));
        applyStimulus(3'd4, 16'h0001, 16'd15, mk(16'h8000, 3'b100, 1'b0, 0));
        applyStimulus(3'd1, 16'hF0F0, 16'h3C3C, mk(16'h3030, 3'b001, 1'b0, 0));
        applyStimulus(3'd0, 16'hFFFF, 16'h0002, mk(16'h0001, 3'b001, 1'b0, 0));
        applyStimulus(3'd5, 16'h4000, 16'h0012, mk(16'h1000, 3'b001, 1'b0, 0));
        idle(2);

        out_ready = 1'b0;
        applyStimulus(3'd7, 16'h1234, 16'h5678, mk(16'h0000, 3'b010, 1'b1, 0));
        idle(5);
        out_ready = 1'b1;
        idle(2);

`ifdef ALU_MUL_EN
        applyStimulus(3'd6, 16'd300, 16'd300, mk(16'h5F90, 3'b001, 1'b0, WIDTH));
        repeat (8) begin
            #4;
            checkOutput("exec_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(3'd0, 16'd3, 16'd4, mk(16'd7, 3'b001, 1'b0, 0));
`else
        applyStimulus(3'd6, 16'd300, 16'd300, mk(16'h0000, 3'b010, 1'b1, 0));
`endif
        idle(2);

        rand_ready = 1'b1;
        repeat (25) begin
            ro = 3'($urandom_range(0, 7));
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            applyStimulus(ro, rx, ry, model(ro, rx, ry));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
        idle(2);

        // Reset in the middle of work: nothing may come out afterwards.
        applyStimulus(3'd0, 16'd5, 16'd6, mk(16'd11, 3'b001, 1'b0, 0));
        idle(2);
`ifdef ALU_MUL_EN
        applyStimulus(3'd6, 16'd300, 16'd300, mk(16'h5F90, 3'b001, 1'b0, WIDTH));
        idle(6);
`else
        out_ready = 1'b0;
        applyStimulus(3'd0, 16'd9, 16'd9, mk(16'd18, 3'b001, 1'b0, 0));
        idle(3);
`endif
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_out", 64'(out), 64'd0);
        checkOutput("arst_nzp", 64'(nzp), 64'b010);
        checkOutput("arst_err", 64'(err), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #4;
        checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("arst_no_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        idle(25);
        applyStimulus(3'd0, 16'd1, 16'd1, mk(16'd2, 3'b001, 1'b0, 0));
        idle(3);
        checkOutput("final_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
